// File: rtl/banked_ram.sv
// Banked RAM with one fixed low window and one switchable high window.
// A CPU port (read/write) and a DMA port (read-only) share a single memory
// port through fixed-priority arbitration, with DMA winning over CPU.
// Physical layout: bank b occupies words [b*HALF, (b+1)*HALF).
// Optional feature macro: RAM_CLEAR_EN. When it is defined, the memory is
// swept to zero after every reset, one word per cycle, while busy is high.
module banked_ram #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 8,
    parameter int BANK_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    output logic                  dma_ack,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    input  logic [BANK_WIDTH-1:0] bank_sel,
    output logic                  busy
);

    localparam int unsigned HALF   = 32'd1 << (ADDR_WIDTH - 1);
    localparam int unsigned NB_U   = NUM_BANKS;
    localparam int unsigned TOTAL  = NB_U * HALF;
    localparam int          PHYS_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    // state | meaning
    // INIT  | clearing memory, requests held off, busy=1
    // READY | accepting CPU/DMA requests
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

`ifdef RAM_CLEAR_EN
    localparam state_t RST_STATE = INIT;
`else
    localparam state_t RST_STATE = READY;
`endif

    state_t                state_q, state_d;
    logic [PHYS_W-1:0]     clr_addr_q, clr_addr_d;
    logic                  clr_we;

    logic [DATA_WIDTH-1:0] mem_q [TOTAL];

    logic                  cpu_ack_q, dma_ack_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, dma_rdata_q;

    logic                  dma_go, cpu_go;
    logic [PHYS_W-1:0]     cpu_pa, dma_pa;
    logic                  mem_we;
    logic [PHYS_W-1:0]     mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    // Window address plus bank select to flat physical word address.
    // Upper half maps to bank (sel mod NUM_BANKS), with bank 0 aliased to 1
    // so the upper window never shadows the fixed lower window.
    function automatic logic [PHYS_W-1:0] map_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [BANK_WIDTH-1:0] sel
    );
        int unsigned bank;
        int unsigned flat;
        bank = 32'(sel) % NB_U;
        if (bank == 0) bank = 1;
        if (!addr[ADDR_WIDTH-1]) bank = 0;
        flat = bank * HALF + 32'(addr[ADDR_WIDTH-2:0]);
        return PHYS_W'(flat);
    endfunction

    // Arbitration: DMA wins on its raw request, so a held dma_req also
    // blocks the CPU during DMA ack cycles (no fairness by design).
    always_comb begin
        dma_go = 1'b0;
        cpu_go = 1'b0;
        if (state_q == READY && !rst) begin
            dma_go = dma_req && !dma_ack_q;
            cpu_go = cpu_req && !cpu_ack_q && !dma_req;
        end
    end

    assign cpu_pa = map_addr(cpu_addr, bank_sel);
    assign dma_pa = map_addr(dma_addr, bank_sel);

    // State register and clear-sweep pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_STATE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next-state logic: sweep every word once, leave INIT after the last one.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            INIT: begin
                clr_we = 1'b1;
                if (clr_addr_q == PHYS_W'(TOTAL - 1)) begin
                    state_d    = READY;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + PHYS_W'(1);
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // Single write port shared by the clear sweep and CPU writes.
    always_comb begin
        mem_we = clr_we || (cpu_go && cpu_we);
        mem_wa = clr_we ? clr_addr_q : cpu_pa;
        mem_wd = clr_we ? '0 : cpu_wdata;
    end

    // Memory array write; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    // Acks and registered read data; reset drops any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            cpu_ack_q <= cpu_go;
            dma_ack_q <= dma_go;
            if (dma_go) dma_rdata_q <= mem_q[dma_pa];
            if (cpu_go && !cpu_we) cpu_rdata_q <= mem_q[cpu_pa];
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign busy      = (state_q == INIT);

endmodule
